// File: rtl/alu_pkg.sv
// Shared types for the ALU operation requester: operator codes, FSM states,
// queued command layout and the reference model used by the result checker.
package alu_pkg;

  localparam logic [7:0] ALU_OP_ADD = 8'h00;
  localparam logic [7:0] ALU_OP_SUB = 8'h01;
  localparam logic [7:0] ALU_OP_AND = 8'h02;
  localparam logic [7:0] ALU_OP_OR  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP
  } req_state_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_cmd_t;

  function automatic logic alu_op_known(input logic [7:0] op);
    return (op <= ALU_OP_OR);
  endfunction

  // Wrap-around 32-bit reference; unknown operators return 0 and are never compared.
  function automatic logic [31:0] alu_model(input logic [7:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] v_res;
    case (op)
      ALU_OP_ADD: v_res = a + b;
      ALU_OP_SUB: v_res = a - b;
      ALU_OP_AND: v_res = a & b;
      ALU_OP_OR:  v_res = a | b;
      default:    v_res = 32'h0;
    endcase
    return v_res;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous command FIFO with show-ahead read port; the reset flushes the
// pointers so the queue is empty afterwards.
module alu_req_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_fire = i_wr_en && !o_full;
  assign w_rd_fire = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/alu_op_requester.sv
// Queued, single-outstanding initiator for the ALU operation interface.
// Optional result checking is enabled by defining ALU_REQ_CHECK_EN.
module alu_op_requester
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_operator,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [7:0]  operator,
  output logic        op_valid,
  input  logic        operation_done,
  input  logic [31:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [7:0]  rsp_operator,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic        busy
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  req_state_t    r_state;
  logic [PW-1:0] r_pulse_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [31:0]   r_operand_a;
  logic [31:0]   r_operand_b;
  logic [7:0]    r_operator;
  logic          r_op_valid;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_result;
  logic [7:0]    r_rsp_operator;
  logic          r_rsp_timeout;
  logic          r_rsp_mismatch;
  logic          r_done_meta;
  logic          r_done_sync;
  logic          r_done_prev;

  alu_cmd_t w_push_cmd;
  alu_cmd_t w_pop_cmd;
  logic     w_fifo_full;
  logic     w_fifo_empty;
  logic     w_pop;
  logic     w_done_event;
  logic     w_mismatch;

  assign w_push_cmd.op = cmd_operator;
  assign w_push_cmd.a  = cmd_a;
  assign w_push_cmd.b  = cmd_b;
  assign w_pop         = (r_state == ST_IDLE) && !w_fifo_empty;

  alu_req_fifo #(
    .WIDTH ($bits(alu_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (cmd_valid),
    .i_wr_data (w_push_cmd),
    .i_rd_en   (w_pop),
    .o_rd_data (w_pop_cmd),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // operation_done is asynchronous to clk: two flops, then a rising-edge detect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_done_meta <= operation_done;
      r_done_sync <= r_done_meta;
      r_done_prev <= r_done_sync;
    end
  end

  assign w_done_event = r_done_sync && !r_done_prev;

`ifdef ALU_REQ_CHECK_EN
  assign w_mismatch = alu_op_known(r_operator) &&
                      (result != alu_model(r_operator, r_operand_a, r_operand_b));
`else
  assign w_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_pulse_cnt    <= '0;
      r_tmo_cnt      <= '0;
      r_operand_a    <= '0;
      r_operand_b    <= '0;
      r_operator     <= '0;
      r_op_valid     <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_operator <= '0;
      r_rsp_timeout  <= 1'b0;
      r_rsp_mismatch <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_operand_a <= w_pop_cmd.a;
            r_operand_b <= w_pop_cmd.b;
            r_operator  <= w_pop_cmd.op;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_op_valid  <= 1'b1;
          r_pulse_cnt <= '0;
          r_tmo_cnt   <= '0;
          r_state     <= ST_ISSUE;
        end
        ST_ISSUE, ST_WAIT_DONE: begin
          if (r_state == ST_ISSUE) begin
            if (r_pulse_cnt == PULSE_LAST) begin
              r_op_valid <= 1'b0;
              r_state    <= ST_WAIT_DONE;
            end else begin
              r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end
          end
          // Later assignments win: a done event pre-empts both the pulse and the timeout.
          if (w_done_event) begin
            r_op_valid     <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= result;
            r_rsp_operator <= r_operator;
            r_rsp_timeout  <= 1'b0;
            r_rsp_mismatch <= w_mismatch;
            r_state        <= ST_RESP;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_op_valid     <= 1'b0;
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= '0;
            r_rsp_operator <= r_operator;
            r_rsp_timeout  <= 1'b1;
            r_rsp_mismatch <= 1'b0;
            r_state        <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = !w_fifo_full;
  assign operand_a    = r_operand_a;
  assign operand_b    = r_operand_b;
  assign operator     = r_operator;
  assign op_valid     = r_op_valid;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_operator = r_rsp_operator;
  assign rsp_timeout  = r_rsp_timeout;
  assign rsp_mismatch = r_rsp_mismatch;
  assign busy         = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_alu_op_requester.sv
// Directed bench for alu_op_requester with a behavioural ALU responder whose
// behaviour (normal, silent, faulty add, slow) is selected per step.
module tb_alu_op_requester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_operator;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [7:0]  operator;
  logic        op_valid;
  logic        operation_done;
  logic [31:0] result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_operator;
  logic        rsp_timeout;
  logic        rsp_mismatch;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ALU_REQ_CHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_op_requester dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_operator   (cmd_operator),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .operator       (operator),
    .op_valid       (op_valid),
    .operation_done (operation_done),
    .result         (result),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_operator   (rsp_operator),
    .rsp_timeout    (rsp_timeout),
    .rsp_mismatch   (rsp_mismatch),
    .busy           (busy)
  );

  // Responder modes: 0 normal, 1 never done, 2 add returns a+b+1, 3 slow done.
  int          rs_mode = 0;
  int          rs_cnt = 0;
  int          rs_hold = 0;
  logic        rs_armed = 1'b0;
  logic        rs_prev = 1'b0;
  logic [31:0] rs_a, rs_b;
  logic [7:0]  rs_op;

  always @(negedge clk) begin
    if (op_valid && !rs_prev) begin
      rs_a = operand_a;
      rs_b = operand_b;
      rs_op = operator;
      operation_done = 1'b0;
      rs_cnt = (rs_mode == 3) ? 20 : 4;
      rs_armed = (rs_mode != 1);
    end else if (rs_armed) begin
      if (rs_cnt == 0) begin
        case (rs_op)
          8'h00:   result = rs_a + rs_b + ((rs_mode == 2) ? 32'd1 : 32'd0);
          8'h01:   result = rs_a - rs_b;
          8'h02:   result = rs_a & rs_b;
          8'h03:   result = rs_a | rs_b;
          default: result = rs_a ^ rs_b;
        endcase
        operation_done = 1'b1;
        rs_hold = 3;
        rs_armed = 1'b0;
      end else begin
        rs_cnt--;
      end
    end else if (rs_hold > 0) begin
      rs_hold--;
      if (rs_hold == 0) operation_done = 1'b0;
    end
    rs_prev = op_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge; returns at the falling edge after acceptance.
  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_operator = op;
    cmd_a = a;
    cmd_b = b;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_wait", 32'(guard < 200), 32'd1);
    @(posedge clk);
    @(negedge clk);
    $display("cmd  op=%02h a=%08h b=%08h", op, a, b);
  endtask

  task automatic get_rsp(input string tag, input logic [31:0] exp_res, input logic [7:0] exp_op,
                         input logic exp_tmo, input logic exp_mis);
    int guard = 0;
    while (!rsp_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_operator"}, 32'(rsp_operator), 32'(exp_op));
    check({tag, "_timeout"}, 32'(rsp_timeout), 32'(exp_tmo));
    check({tag, "_mismatch"}, 32'(rsp_mismatch), 32'(exp_mis));
    $display("rsp  %s op=%02h result=%08h timeout=%0d mismatch=%0d",
             tag, rsp_operator, rsp_result, rsp_timeout, rsp_mismatch);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_op_valid(input logic level);
    int guard = 0;
    while (op_valid !== level && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("op_valid_wait", 32'(op_valid), 32'(level));
  endtask

  initial begin
    int lat;
    int width;
    int t;
    logic seen;

    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_operator = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b0;
    operation_done = 1'b0;
    result = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_operand_a", operand_a, 32'd0);
    check("rst_operator", 32'(operator), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single add: latency to op_valid, pulse width, operands.
    send_cmd(8'h00, 32'h5, 32'h3);
    cmd_valid = 1'b0;
    lat = 1;
    while (!op_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("issue_latency", 32'(lat), 32'd3);
    check("add_operand_a", operand_a, 32'h5);
    check("add_operand_b", operand_b, 32'h3);
    width = 0;
    while (op_valid && width < 20) begin
      width++;
      @(negedge clk);
    end
    check("op_valid_width", 32'(width), 32'd2);
    get_rsp("add", 32'h8, 8'h00, 1'b0, 1'b0);

    send_cmd(8'h01, 32'h0, 32'h1);
    cmd_valid = 1'b0;
    get_rsp("sub_wrap", 32'hFFFF_FFFF, 8'h01, 1'b0, 1'b0);

    // Back-to-back commands fill the queue while the first response is held.
    send_cmd(8'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    send_cmd(8'h01, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    send_cmd(8'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    send_cmd(8'h03, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    send_cmd(8'h00, 32'h10, 32'h20);
    cmd_valid = 1'b0;
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_result", rsp_result, 32'h00E1_00E0);
      check("hold_op_valid", 32'(op_valid), 32'd0);
      @(negedge clk);
    end
    get_rsp("q_add", 32'h00E1_00E0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("drain_cmd_ready", 32'(cmd_ready), 32'd1);
    get_rsp("q_sub", 32'hE100_E100, 8'h01, 1'b0, 1'b0);
    get_rsp("q_and", 32'h00F0_00F0, 8'h02, 1'b0, 1'b0);
    get_rsp("q_or", 32'hFFF0_FFF0, 8'h03, 1'b0, 1'b0);
    get_rsp("q_add2", 32'h30, 8'h00, 1'b0, 1'b0);

    // Silent responder: timeout exactly TIMEOUT_CYCLES after op_valid rises.
    rs_mode = 1;
    send_cmd(8'h00, 32'h7, 32'h8);
    cmd_valid = 1'b0;
    wait_op_valid(1'b1);
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("timeout_cycles", 32'(t), 32'd64);
    get_rsp("timeout", 32'h0, 8'h00, 1'b1, 1'b0);
    rs_mode = 0;
    send_cmd(8'h03, 32'h1, 32'h2);
    cmd_valid = 1'b0;
    get_rsp("after_tmo", 32'h3, 8'h03, 1'b0, 1'b0);

    // Faulty add from the ALU; other operators stay correct.
    rs_mode = 2;
    send_cmd(8'h00, 32'h5, 32'h3);
    cmd_valid = 1'b0;
    get_rsp("bad_add", 32'h9, 8'h00, 1'b0, EXP_MIS);
    send_cmd(8'h01, 32'h9, 32'h4);
    cmd_valid = 1'b0;
    get_rsp("ok_sub", 32'h5, 8'h01, 1'b0, 1'b0);
    send_cmd(8'h07, 32'hFF00, 32'h0F0F);
    cmd_valid = 1'b0;
    get_rsp("unk_op", 32'hF00F, 8'h07, 1'b0, 1'b0);
    rs_mode = 0;

    // Reset during WAIT_DONE; done arrives afterwards and must be ignored.
    rs_mode = 3;
    send_cmd(8'h00, 32'h1, 32'h1);
    cmd_valid = 1'b0;
    wait_op_valid(1'b1);
    wait_op_valid(1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_op_valid", 32'(op_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("post_rst_no_rsp", 32'(seen), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rs_mode = 0;
    send_cmd(8'h00, 32'h1, 32'h2);
    cmd_valid = 1'b0;
    get_rsp("post_rst_add", 32'h3, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
